// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with load-use, branch and memory-wait hazards
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int MEM_LAT    = 1,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_vld,
  input  logic [REG_W-1:0]                  id_rs1,
  input  logic [REG_W-1:0]                  id_rs2,
  input  logic                              id_use_rs1,
  input  logic                              id_use_rs2,
  input  logic [NUM_STAGES-4:0]             pipe_vld,
  input  logic [NUM_STAGES-4:0]             pipe_ld,
  input  logic [(NUM_STAGES-3)*REG_W-1:0]   pipe_rd,
  input  logic                              ex_vld,
  input  logic                              ex_take_br,
  input  logic                              mem_vld,
  input  logic                              mem_is_mem,
  output logic [NUM_STAGES-1:0]             stage_en,
  output logic [NUM_STAGES-1:0]             stage_flush,
  output logic [CNT_W-1:0]                  stall_cnt,
  output logic [CNT_W-1:0]                  flush_cnt
);

  localparam int NLD    = NUM_STAGES - 3;
  localparam int MEM    = NUM_STAGES - 2;
  localparam int WB     = NUM_STAGES - 1;
  localparam int WAIT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MEM_LAT > 2) ? (MEM_LAT - 2) : 0);

  typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic              guard, guard_nxt;
  logic              ld_use;
  logic              mem_stall;
  logic              br_act;

  always_comb begin
    ld_use = 1'b0;
    for (int k = 0; k < NLD; k++) begin
      if (pipe_vld[k] && pipe_ld[k] && (pipe_rd[k*REG_W +: REG_W] != '0) &&
          ((id_use_rs1 && (pipe_rd[k*REG_W +: REG_W] == id_rs1)) ||
           (id_use_rs2 && (pipe_rd[k*REG_W +: REG_W] == id_rs2)))) begin
        ld_use = 1'b1;
      end
    end
    ld_use = ld_use & id_vld;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    guard_nxt   = 1'b0;
    mem_stall   = 1'b0;
    br_act      = 1'b0;
    stage_en    = '1;
    stage_flush = '0;
    if (rst) begin
      stage_en    = '0;
      stage_flush = '1;
    end else begin
      if (state == ST_MEM_WAIT) begin
        if (cnt != '0) begin
          mem_stall = 1'b1;
          cnt_nxt   = cnt - WAIT_W'(1);
        end else begin
          state_nxt = ST_RUN;
        end
      end else if ((MEM_LAT > 1) && mem_vld && mem_is_mem && !guard) begin
        mem_stall = 1'b1;
        // A two-cycle op needs no counter: the guard lets the same op release next cycle.
        if (MEM_LAT == 2) begin
          guard_nxt = 1'b1;
        end else begin
          state_nxt = ST_MEM_WAIT;
          cnt_nxt   = WAIT_INIT;
        end
      end

      if (mem_stall) begin
        stage_en[MEM:0] = '0;
        stage_flush[WB] = 1'b1;
      end else if (ex_vld && ex_take_br) begin
        br_act           = 1'b1;
        stage_flush[2:1] = 2'b11;
      end else if (ld_use) begin
        stage_en[1:0]  = 2'b00;
        stage_flush[2] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      cnt       <= '0;
      guard     <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      guard <= guard_nxt;
      if (!stage_en[0] && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (br_act && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - checks pipe_hazard_ctrl at MEM_LAT 1..4 plus a narrow-counter instance
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_vld, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2;
  logic [1:0] pipe_vld, pipe_ld;
  logic [9:0] pipe_rd;
  logic       ex_vld, ex_take_br, mem_vld, mem_is_mem;

  logic [4:0]  en_o [5];
  logic [4:0]  fl_o [5];
  logic [31:0] sc_o [4];
  logic [31:0] fc_o [4];
  logic [2:0]  sc_s, fc_s;

  int     checks = 0;
  int     errors = 0;
  int     lat [5]  = '{1, 2, 3, 4, 2};
  longint cmax [5] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'd7};

  int     age [5];
  longint m_sc [5];
  longint m_fc [5];

  logic [4:0]  obs_en [5];
  logic [4:0]  obs_fl [5];
  logic [31:0] obs_sc [5];
  logic [31:0] obs_fc [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pipe_hazard_ctrl #(.NUM_STAGES(5), .MEM_LAT(g + 1), .REG_W(5), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .pipe_vld(pipe_vld),
      .pipe_ld(pipe_ld), .pipe_rd(pipe_rd), .ex_vld(ex_vld), .ex_take_br(ex_take_br),
      .mem_vld(mem_vld), .mem_is_mem(mem_is_mem), .stage_en(en_o[g]),
      .stage_flush(fl_o[g]), .stall_cnt(sc_o[g]), .flush_cnt(fc_o[g]));
  end

  pipe_hazard_ctrl #(.NUM_STAGES(5), .MEM_LAT(2), .REG_W(5), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .pipe_vld(pipe_vld),
    .pipe_ld(pipe_ld), .pipe_rd(pipe_rd), .ex_vld(ex_vld), .ex_take_br(ex_take_br),
    .mem_vld(mem_vld), .mem_is_mem(mem_is_mem), .stage_en(en_o[4]),
    .stage_flush(fl_o[4]), .stall_cnt(sc_s), .flush_cnt(fc_s));

  typedef struct {
    string      name;
    logic       idv;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [1:0] pv, pl;
    logic [9:0] prd;
    logic       exv, br;
    logic [4:0] en, fl;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: an op sits in MEM for MEM_LAT cycles; age counts the cycles it has already stalled.
  function automatic void model_out(input int i, output logic [4:0] e_en, output logic [4:0] e_fl,
                                    output bit m_st, output bit b_f);
    bit lu;
    logic [4:0] rd;
    m_st = 1'b0;
    b_f  = 1'b0;
    if (rst) begin
      e_en = 5'b00000;
      e_fl = 5'b11111;
      return;
    end
    if (age[i] > 0) m_st = (age[i] < lat[i] - 1);
    else            m_st = (lat[i] > 1) && mem_vld && mem_is_mem;
    lu = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd = pipe_rd[k*5 +: 5];
      if (pipe_vld[k] && pipe_ld[k] && rd != 0 &&
          ((id_use_rs1 && rd == id_rs1) || (id_use_rs2 && rd == id_rs2))) lu = 1'b1;
    end
    lu = lu && id_vld;
    if (m_st) begin
      e_en = 5'b10000; e_fl = 5'b10000;
    end else if (ex_vld && ex_take_br) begin
      e_en = 5'b11111; e_fl = 5'b00110; b_f = 1'b1;
    end else if (lu) begin
      e_en = 5'b11100; e_fl = 5'b00100;
    end else begin
      e_en = 5'b11111; e_fl = 5'b00000;
    end
  endfunction

  task automatic tick();
    logic [4:0] e_en [5];
    logic [4:0] e_fl [5];
    bit ms [5];
    bit bf [5];
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      obs_en[i] = en_o[i];
      obs_fl[i] = fl_o[i];
      if (i < 4) begin
        obs_sc[i] = sc_o[i];
        obs_fc[i] = fc_o[i];
      end else begin
        obs_sc[i] = {29'd0, sc_s};
        obs_fc[i] = {29'd0, fc_s};
      end
      model_out(i, e_en[i], e_fl[i], ms[i], bf[i]);
      chk($sformatf("model_en[%0d]", i), {27'd0, obs_en[i]}, {27'd0, e_en[i]});
      chk($sformatf("model_fl[%0d]", i), {27'd0, obs_fl[i]}, {27'd0, e_fl[i]});
      chk($sformatf("model_sc[%0d]", i), obs_sc[i], m_sc[i][31:0]);
      chk($sformatf("model_fc[%0d]", i), obs_fc[i], m_fc[i][31:0]);
    end
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      if (rst) begin
        age[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        age[i] = ms[i] ? age[i] + 1 : 0;
        if (!e_en[i][0] && m_sc[i] < cmax[i]) m_sc[i]++;
        if (bf[i] && m_fc[i] < cmax[i]) m_fc[i]++;
      end
    end
    #1;
  endtask

  task automatic clr_in();
    id_vld = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    pipe_vld = 0; pipe_ld = 0; pipe_rd = 0;
    ex_vld = 0; ex_take_br = 0; mem_vld = 0; mem_is_mem = 0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1; tick(); tick();
    rst = 0;
  endtask

  task automatic set_lu();
    id_vld = 1; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 1; id_use_rs2 = 1;
    pipe_vld = 2'b01; pipe_ld = 2'b01; pipe_rd = 10'd5;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 5; i++) begin age[i] = 0; m_sc[i] = 0; m_fc[i] = 0; end
    clr_in();
    rst = 1;
    #1;

    // reset values and release
    tick(); tick();
    chk("rst_en", {27'd0, obs_en[0]}, 32'h00);
    chk("rst_fl", {27'd0, obs_fl[0]}, 32'h1f);
    chk("rst_sc", obs_sc[0], 0);
    chk("rst_fc", obs_fc[0], 0);
    rst = 0;
    tick();
    chk("post_rst_en", {27'd0, obs_en[0]}, 32'h1f);

    // combinational vectors on the MEM_LAT=1 instance
    vecs.push_back('{"idle",     0, 0, 0, 0, 0, 2'b00, 2'b00, 10'd0,         0, 0, 5'b11111, 5'b00000});
    vecs.push_back('{"lu_rs1",   1, 5, 1, 1, 0, 2'b01, 2'b01, 10'd5,         0, 0, 5'b11100, 5'b00100});
    vecs.push_back('{"lu_rs2",   1, 3, 5, 1, 1, 2'b01, 2'b01, 10'd5,         0, 0, 5'b11100, 5'b00100});
    vecs.push_back('{"rs2_nuse", 1, 3, 5, 1, 0, 2'b01, 2'b01, 10'd5,         0, 0, 5'b11111, 5'b00000});
    vecs.push_back('{"x0_load",  1, 0, 0, 1, 1, 2'b01, 2'b01, 10'd0,         0, 0, 5'b11111, 5'b00000});
    vecs.push_back('{"no_load",  1, 5, 0, 1, 0, 2'b01, 2'b00, 10'd5,         0, 0, 5'b11111, 5'b00000});
    vecs.push_back('{"no_pvld",  1, 5, 0, 1, 0, 2'b00, 2'b01, 10'd5,         0, 0, 5'b11111, 5'b00000});
    vecs.push_back('{"no_idvld", 0, 5, 0, 1, 0, 2'b01, 2'b01, 10'd5,         0, 0, 5'b11111, 5'b00000});
    vecs.push_back('{"lu_k1",    1, 2, 7, 1, 1, 2'b10, 2'b10, {5'd7, 5'd0},  0, 0, 5'b11100, 5'b00100});
    vecs.push_back('{"br_lu",    1, 5, 0, 1, 0, 2'b01, 2'b01, 10'd5,         1, 1, 5'b11111, 5'b00110});
    vecs.push_back('{"br_noex",  1, 5, 0, 1, 0, 2'b01, 2'b01, 10'd5,         0, 1, 5'b11100, 5'b00100});
    vecs.push_back('{"br_only",  0, 0, 0, 0, 0, 2'b00, 2'b00, 10'd0,         1, 1, 5'b11111, 5'b00110});
    foreach (vecs[v]) begin
      id_vld = vecs[v].idv; id_rs1 = vecs[v].rs1; id_rs2 = vecs[v].rs2;
      id_use_rs1 = vecs[v].u1; id_use_rs2 = vecs[v].u2;
      pipe_vld = vecs[v].pv; pipe_ld = vecs[v].pl; pipe_rd = vecs[v].prd;
      ex_vld = vecs[v].exv; ex_take_br = vecs[v].br;
      tick();
      chk({"vec_en_", vecs[v].name}, {27'd0, obs_en[0]}, {27'd0, vecs[v].en});
      chk({"vec_fl_", vecs[v].name}, {27'd0, obs_fl[0]}, {27'd0, vecs[v].fl});
    end

    // load-use stalls exactly one cycle once the bubble reaches EX
    do_reset();
    set_lu();
    tick();
    chk("lu_en", {27'd0, obs_en[0]}, 32'h1c);
    chk("lu_fl", {27'd0, obs_fl[0]}, 32'h04);
    pipe_vld = 2'b00; mem_vld = 1; mem_is_mem = 1;
    tick();
    chk("lu_after_en", {27'd0, obs_en[0]}, 32'h1f);
    chk("lu_stall_cnt", obs_sc[0], 1);

    // branch wins over load-use
    do_reset();
    set_lu(); ex_vld = 1; ex_take_br = 1;
    tick();
    chk("br_en", {27'd0, obs_en[0]}, 32'h1f);
    chk("br_fl", {27'd0, obs_fl[0]}, 32'h06);
    clr_in();
    tick();
    chk("br_flush_cnt", obs_fc[0], 1);
    chk("br_stall_cnt", obs_sc[0], 0);

    // single memory op: MEM_LAT-1 contiguous stall cycles per instance
    do_reset();
    mem_vld = 1; mem_is_mem = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) clr_in();
      for (int i = 0; i < 4; i++)
        chk($sformatf("memw_stall_l%0d_c%0d", lat[i], c), {31'd0, ~obs_en[i][0]},
            {31'd0, (c < lat[i] - 1)});
      if (c < 2) begin
        chk($sformatf("memw_en_l3_c%0d", c), {27'd0, obs_en[2]}, 32'h10);
        chk($sformatf("memw_fl_l3_c%0d", c), {27'd0, obs_fl[2]}, 32'h10);
      end
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("memw_sc_l%0d", lat[i]), obs_sc[i], lat[i] - 1);

    // back-to-back memory ops at MEM_LAT=2
    do_reset();
    mem_vld = 1; mem_is_mem = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("b2b_en0_c%0d", c), {31'd0, obs_en[1][0]}, {31'd0, c[0]});
    end
    clr_in();
    tick();
    chk("b2b_sc", obs_sc[1], 2);

    // reset in the middle of a MEM_LAT=4 wait
    do_reset();
    mem_vld = 1; mem_is_mem = 1;
    tick();
    clr_in();
    tick();
    chk("rmw_stalled", {31'd0, obs_en[3][0]}, 0);
    rst = 1; tick();
    rst = 0; tick();
    chk("rmw_run_en", {27'd0, obs_en[3]}, 32'h1f);
    mem_vld = 1; mem_is_mem = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) clr_in();
      chk($sformatf("rmw_stall_c%0d", c), {31'd0, ~obs_en[3][0]}, {31'd0, (c < 3)});
    end

    // counter saturation on the 3-bit instance
    do_reset();
    set_lu();
    for (int c = 0; c < 10; c++) tick();
    ex_vld = 1; ex_take_br = 1;
    for (int c = 0; c < 9; c++) tick();
    clr_in();
    tick();
    chk("sat_sc", obs_sc[4], 7);
    chk("wide_sc", obs_sc[0], 10);
    chk("sat_fc", obs_fc[4], 7);
    chk("wide_fc", obs_fc[0], 9);

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      id_vld     = $urandom_range(0, 3) != 0;
      id_rs1     = 5'($urandom_range(0, 3));
      id_rs2     = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom);
      id_use_rs2 = 1'($urandom);
      pipe_vld   = 2'($urandom);
      pipe_ld    = 2'($urandom);
      pipe_rd    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_vld     = 1'($urandom);
      ex_take_br = $urandom_range(0, 4) == 0;
      mem_vld    = $urandom_range(0, 2) == 0;
      mem_is_mem = 1'($urandom);
      tick();
    end
    rst = 0;
    clr_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
